sdl_frame_checker: RTL and testbench

- Byte-stream frame receiver/checker directly downstream of the test-frame generator (s2p byte stream + valid).
- Validates each fixed-length frame: lead byte, sync words, address field, control word, incrementing payload.
- Reports frame kind, gear (dangwei) and per-frame result, and keeps saturating statistics for bench and ILA observation.

---
 rtl/sdl_frame_checker.sv | 185 ++++++++++++++++++
 tb/tb_sdl_frame_checker.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sdl_frame_checker.sv
// Receiver/checker for fixed-length test frames: validates lead, sync, address,
// control word and incrementing payload, and keeps saturating statistics.
module sdl_frame_checker #(
    parameter int FRAME_LEN = 2048,
    parameter int HDR_LEN   = 22
) (
    input  logic        sys_clk_i,
    input  logic        rst_i,
    input  logic [7:0]  s2p_din_i,
    input  logic        din_valid_i,
    input  logic        clr_stats_i,
    output logic        frame_done_o,
    output logic        frame_ok_o,
    output logic [1:0]  frame_kind_o,
    output logic [7:0]  dangwei_o,
    output logic [3:0]  err_flags_o,
    output logic [15:0] frame_cnt_o,
    output logic [15:0] bad_cnt_o,
    output logic [15:0] byte_err_cnt_o,
    output logic [2:0]  fsm_state_o
);

    localparam int IDX_W = $clog2(FRAME_LEN);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_HUNT = 3'd1;
    localparam logic [2:0] S_HDR  = 3'd2;
    localparam logic [2:0] S_PAY  = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    localparam logic [7:0] LEAD_BB = 8'hBB;
    localparam logic [7:0] LEAD_BD = 8'hBD;

    logic [2:0]       state, state_nxt;
    logic [IDX_W-1:0] idx;
    logic [7:0]       idx8;
    logic             lead_bd;
    logic [7:0]       ctrl_hi;
    logic [2:0]       pay_type;

    logic       is_lead, start, in_frame, frame_byte;
    logic       at_ctrl_hi, at_ctrl_lo, at_last;
    logic [7:0] hdr_exp, pay_exp;
    logic       sync_err, addr_err, ctrl_err, pay_err;
    logic [2:0] new_type;
    logic [7:0] new_dw;
    logic [1:0] new_kind;
    logic [3:0] flags_nxt;
    logic       finish, abort, last_byte, good;

    assign fsm_state_o = state;
    assign idx8        = 8'(idx);

    assign is_lead    = (s2p_din_i == LEAD_BB) || (s2p_din_i == LEAD_BD);
    assign start      = din_valid_i && is_lead && ((state == S_IDLE) || (state == S_DONE));
    assign in_frame   = (state == S_HDR) || (state == S_PAY);
    assign frame_byte = din_valid_i && in_frame;
    assign at_ctrl_hi = (idx == IDX_W'(HDR_LEN - 2));
    assign at_ctrl_lo = (idx == IDX_W'(HDR_LEN - 1));
    assign at_last    = (idx == IDX_W'(FRAME_LEN - 1));

    always_comb begin
        hdr_exp = 8'hFF;
        case (idx)
            IDX_W'(1):            hdr_exp = 8'h00;
            IDX_W'(2), IDX_W'(4): hdr_exp = 8'h07;
            IDX_W'(3), IDX_W'(5): hdr_exp = 8'hF9;
            default:              hdr_exp = 8'hFF;
        endcase
    end

    // Control word is {b20,b21} = {5'd9, dangwei[7:0], type[2:0]}.
    assign new_type = s2p_din_i[2:0];
    assign new_dw   = {ctrl_hi[2:0], s2p_din_i[7:3]};

    always_comb begin
        new_kind = 2'd0;
        if (lead_bd) begin
            new_kind = 2'd3;
        end else begin
            case (new_type)
                3'd1:    new_kind = 2'd0;
                3'd2:    new_kind = 2'd1;
                3'd3:    new_kind = 2'd2;
                default: new_kind = 2'd0;
            endcase
        end
    end

    assign pay_exp = lead_bd ? (idx8 - 8'd22) : (idx8 - 8'd18 - {5'd0, pay_type});

    assign sync_err = frame_byte && (state == S_HDR) && (idx <= IDX_W'(5))
                      && (s2p_din_i != hdr_exp);
    assign addr_err = frame_byte && (state == S_HDR) && (idx >= IDX_W'(6))
                      && (idx < IDX_W'(HDR_LEN - 2)) && (s2p_din_i != hdr_exp);
    assign ctrl_err = frame_byte && (state == S_HDR) && at_ctrl_lo
                      && ((ctrl_hi[7:3] != 5'd9)
                          || (lead_bd ? (new_type != 3'd3)
                                      : ((new_type == 3'd0) || (new_type > 3'd3))));
    assign pay_err  = frame_byte && (state == S_PAY) && (s2p_din_i != pay_exp);

    assign flags_nxt = err_flags_o | {pay_err, ctrl_err, addr_err, sync_err};
    assign last_byte = frame_byte && (state == S_PAY) && at_last;
    assign abort     = !din_valid_i && in_frame;
    assign finish    = last_byte || abort;
    assign good      = last_byte && (flags_nxt == 4'd0);

    // DONE accepts a new lead byte exactly like IDLE so gap-less streams stay aligned.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_DONE: begin
                if (din_valid_i) state_nxt = is_lead ? S_HDR : S_HUNT;
                else             state_nxt = S_IDLE;
            end
            S_HUNT: state_nxt = din_valid_i ? S_HUNT : S_IDLE;
            S_HDR: begin
                if (!din_valid_i)    state_nxt = S_DONE;
                else if (at_ctrl_lo) state_nxt = S_PAY;
            end
            S_PAY: begin
                if (!din_valid_i || at_last) state_nxt = S_DONE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk_i or posedge rst_i) begin
        if (rst_i) begin
            state        <= S_IDLE;
            idx          <= '0;
            lead_bd      <= 1'b0;
            ctrl_hi      <= 8'd0;
            pay_type     <= 3'd0;
            frame_done_o <= 1'b0;
            frame_ok_o   <= 1'b0;
            frame_kind_o <= 2'd0;
            dangwei_o    <= 8'd0;
            err_flags_o  <= 4'd0;
        end else begin
            state        <= state_nxt;
            frame_done_o <= finish;
            if (start) begin
                lead_bd     <= (s2p_din_i == LEAD_BD);
                err_flags_o <= 4'd0;
                idx         <= IDX_W'(1);
            end else if (frame_byte) begin
                idx         <= idx + IDX_W'(1);
                err_flags_o <= flags_nxt;
            end
            if (frame_byte && (state == S_HDR) && at_ctrl_hi) begin
                ctrl_hi <= s2p_din_i;
            end
            if (frame_byte && (state == S_HDR) && at_ctrl_lo) begin
                pay_type     <= new_type;
                dangwei_o    <= new_dw;
                frame_kind_o <= new_kind;
            end
            if (finish) begin
                frame_ok_o <= good;
            end
        end
    end

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_ff @(posedge sys_clk_i or posedge rst_i) begin
        if (rst_i) begin
            frame_cnt_o    <= 16'd0;
            bad_cnt_o      <= 16'd0;
            byte_err_cnt_o <= 16'd0;
        end else if (clr_stats_i) begin
            frame_cnt_o    <= 16'd0;
            bad_cnt_o      <= 16'd0;
            byte_err_cnt_o <= 16'd0;
        end else begin
            if (good)               frame_cnt_o    <= sat_inc(frame_cnt_o);
            if (finish && !good)    bad_cnt_o      <= sat_inc(bad_cnt_o);
            if (pay_err)            byte_err_cnt_o <= sat_inc(byte_err_cnt_o);
        end
    end

endmodule

// File: tb/tb_sdl_frame_checker.sv
// Bench for sdl_frame_checker: table of whole frames with expected results,
// plus hand sequences for abort, junk hunting and mid-frame reset.
`timescale 1ns/1ps
module tb_sdl_frame_checker;

    localparam int FRAME_LEN = 2048;
    localparam int HDR_LEN   = 22;
    localparam int NVEC      = 11;

    logic        sys_clk_i = 1'b0;
    logic        rst_i;
    logic [7:0]  s2p_din_i;
    logic        din_valid_i;
    logic        clr_stats_i;
    logic        frame_done_o;
    logic        frame_ok_o;
    logic [1:0]  frame_kind_o;
    logic [7:0]  dangwei_o;
    logic [3:0]  err_flags_o;
    logic [15:0] frame_cnt_o;
    logic [15:0] bad_cnt_o;
    logic [15:0] byte_err_cnt_o;
    logic [2:0]  fsm_state_o;

    sdl_frame_checker #(.FRAME_LEN(FRAME_LEN), .HDR_LEN(HDR_LEN)) dut (
        .sys_clk_i      (sys_clk_i),
        .rst_i          (rst_i),
        .s2p_din_i      (s2p_din_i),
        .din_valid_i    (din_valid_i),
        .clr_stats_i    (clr_stats_i),
        .frame_done_o   (frame_done_o),
        .frame_ok_o     (frame_ok_o),
        .frame_kind_o   (frame_kind_o),
        .dangwei_o      (dangwei_o),
        .err_flags_o    (err_flags_o),
        .frame_cnt_o    (frame_cnt_o),
        .bad_cnt_o      (bad_cnt_o),
        .byte_err_cnt_o (byte_err_cnt_o),
        .fsm_state_o    (fsm_state_o)
    );

    // Handshake: a byte is transferred on every rising edge where din_valid_i is high;
    // the checker never back-pressures.
    always #5 sys_clk_i = ~sys_clk_i;

    typedef struct {
        logic [7:0]  lead;
        logic [4:0]  top5;
        logic [2:0]  typ;
        logic [7:0]  dw;
        int          bad_idx;
        logic [7:0]  bad_val;
        logic        exp_ok;
        logic [1:0]  exp_kind;
        logic [3:0]  exp_flags;
        logic        chk_cnt;
        logic [15:0] exp_good;
        logic [15:0] exp_bad;
        logic [15:0] exp_berr;
    } vec_t;

    vec_t        vecs[NVEC];
    logic [14:0] exp_q[$];
    logic [14:0] mon_e;
    int          n_tests = 0;
    int          n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] gen_byte(input logic [7:0] lead, input logic [4:0] top5,
                                            input logic [2:0] typ, input logic [7:0] dw,
                                            input int idx);
        if (idx == 0)                  return lead;
        if (idx == 1)                  return 8'h00;
        if (idx == 2 || idx == 4)      return 8'h07;
        if (idx == 3 || idx == 5)      return 8'hF9;
        if (idx < 20)                  return 8'hFF;
        if (idx == 20)                 return {top5, dw[7:5]};
        if (idx == 21)                 return {dw[4:0], typ};
        if (lead == 8'hBD)             return 8'(idx - 22);
        return 8'(idx - 18 - int'(typ));
    endfunction

    task automatic push_exp(input logic ok, input logic [1:0] kind, input logic [3:0] flags,
                            input logic [7:0] dw);
        exp_q.push_back({ok, kind, flags, dw});
    endtask

    task automatic send_frame(input logic [7:0] lead, input logic [4:0] top5,
                              input logic [2:0] typ, input logic [7:0] dw,
                              input int bad_idx, input logic [7:0] bad_val,
                              input int drop_idx, input int rst_idx);
        for (int i = 0; i < FRAME_LEN; i++) begin
            @(negedge sys_clk_i);
            if (i == drop_idx) begin
                din_valid_i = 1'b0;
                return;
            end
            if (i == rst_idx) begin
                din_valid_i = 1'b0;
                rst_i       = 1'b1;
                @(negedge sys_clk_i);
                rst_i       = 1'b0;
                return;
            end
            s2p_din_i   = (i == bad_idx) ? bad_val : gen_byte(lead, top5, typ, dw, i);
            din_valid_i = 1'b1;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge sys_clk_i);
            din_valid_i = 1'b0;
            s2p_din_i   = 8'h00;
        end
    endtask

    task automatic check_counts(input string tag, input logic [15:0] good,
                                input logic [15:0] bad, input logic [15:0] berr);
        check({tag, "_frame_cnt"}, 32'(frame_cnt_o), 32'(good));
        check({tag, "_bad_cnt"}, 32'(bad_cnt_o), 32'(bad));
        check({tag, "_byte_err_cnt"}, 32'(byte_err_cnt_o), 32'(berr));
    endtask

    task automatic clear_stats();
        @(negedge sys_clk_i);
        clr_stats_i = 1'b1;
        @(negedge sys_clk_i);
        clr_stats_i = 1'b0;
        check_counts("clr", 16'd0, 16'd0, 16'd0);
    endtask

    // Scoreboard: each frame_done_o pulse consumes the oldest expected result.
    always @(negedge sys_clk_i) begin
        if (!rst_i && frame_done_o) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 32'(frame_done_o), 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check("frame_ok", 32'(frame_ok_o), 32'(mon_e[14]));
                check("frame_kind", 32'(frame_kind_o), 32'(mon_e[13:12]));
                check("err_flags", 32'(err_flags_o), 32'(mon_e[11:8]));
                check("dangwei", 32'(dangwei_o), 32'(mon_e[7:0]));
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0]  = '{8'hBB, 5'd9, 3'd1, 8'hC3, -1,   8'h00, 1'b1, 2'd0, 4'h0, 1'b0, 16'd0, 16'd0, 16'd0};
        vecs[1]  = '{8'hBB, 5'd9, 3'd2, 8'hC3, -1,   8'h00, 1'b1, 2'd1, 4'h0, 1'b0, 16'd0, 16'd0, 16'd0};
        vecs[2]  = '{8'hBB, 5'd9, 3'd3, 8'hC3, -1,   8'h00, 1'b1, 2'd2, 4'h0, 1'b0, 16'd0, 16'd0, 16'd0};
        vecs[3]  = '{8'hBD, 5'd9, 3'd3, 8'hC3, -1,   8'h00, 1'b1, 2'd3, 4'h0, 1'b1, 16'd4, 16'd0, 16'd0};
        vecs[4]  = '{8'hBB, 5'd9, 3'd2, 8'hC3, 100,  8'h51, 1'b0, 2'd1, 4'h8, 1'b1, 16'd0, 16'd1, 16'd1};
        vecs[5]  = '{8'hBB, 5'd9, 3'd0, 8'h5A, -1,   8'h00, 1'b0, 2'd0, 4'h4, 1'b0, 16'd0, 16'd0, 16'd0};
        vecs[6]  = '{8'hBD, 5'd9, 3'd2, 8'hA5, -1,   8'h00, 1'b0, 2'd3, 4'h4, 1'b1, 16'd0, 16'd2, 16'd0};
        vecs[7]  = '{8'hBB, 5'd8, 3'd1, 8'h11, -1,   8'h00, 1'b0, 2'd0, 4'h4, 1'b0, 16'd0, 16'd0, 16'd0};
        vecs[8]  = '{8'hBB, 5'd9, 3'd1, 8'hC3, 3,    8'h00, 1'b0, 2'd0, 4'h1, 1'b0, 16'd0, 16'd0, 16'd0};
        vecs[9]  = '{8'hBB, 5'd9, 3'd3, 8'hC3, 10,   8'h00, 1'b0, 2'd2, 4'h2, 1'b0, 16'd0, 16'd0, 16'd0};
        vecs[10] = '{8'hBD, 5'd9, 3'd3, 8'hC3, 2047, 8'h00, 1'b0, 2'd3, 4'h8, 1'b1, 16'd0, 16'd4, 16'd1};

        rst_i       = 1'b1;
        s2p_din_i   = 8'h00;
        din_valid_i = 1'b0;
        clr_stats_i = 1'b0;
        repeat (3) @(negedge sys_clk_i);
        check("rst_done", 32'(frame_done_o), 32'd0);
        check("rst_ok", 32'(frame_ok_o), 32'd0);
        check("rst_kind_dw_flags", {18'd0, frame_kind_o, dangwei_o, err_flags_o}, 32'd0);
        check("rst_state", 32'(fsm_state_o), 32'd0);
        check_counts("rst", 16'd0, 16'd0, 16'd0);
        rst_i = 1'b0;
        idle(2);

        for (int v = 0; v < NVEC; v++) begin
            push_exp(vecs[v].exp_ok, vecs[v].exp_kind, vecs[v].exp_flags, vecs[v].dw);
            send_frame(vecs[v].lead, vecs[v].top5, vecs[v].typ, vecs[v].dw,
                       vecs[v].bad_idx, vecs[v].bad_val, -1, -1);
            idle(1);
            if (vecs[v].chk_cnt) begin
                idle(2);
                check_counts($sformatf("vec%0d", v), vecs[v].exp_good, vecs[v].exp_bad,
                             vecs[v].exp_berr);
                clear_stats();
            end
        end

        // Valid drops at index 1000, then a clean frame follows.
        push_exp(1'b0, 2'd0, 4'h0, 8'h77);
        send_frame(8'hBB, 5'd9, 3'd1, 8'h77, -1, 8'h00, 1000, -1);
        idle(1);
        push_exp(1'b1, 2'd2, 4'h0, 8'hC3);
        send_frame(8'hBB, 5'd9, 3'd3, 8'hC3, -1, 8'h00, -1, -1);
        idle(3);
        check_counts("abort", 16'd1, 16'd1, 16'd0);
        clear_stats();

        // Junk bytes are hunted through without being counted.
        for (int j = 0; j < 10; j++) begin
            @(negedge sys_clk_i);
            s2p_din_i   = 8'h55;
            din_valid_i = 1'b1;
        end
        idle(1);
        push_exp(1'b1, 2'd2, 4'h0, 8'hC3);
        send_frame(8'hBB, 5'd9, 3'd3, 8'hC3, -1, 8'h00, -1, -1);
        idle(3);
        check_counts("junk", 16'd1, 16'd0, 16'd0);
        clear_stats();

        // Gap-less pair with reset in the middle of the second frame.
        push_exp(1'b1, 2'd0, 4'h0, 8'hC3);
        send_frame(8'hBB, 5'd9, 3'd1, 8'hC3, -1, 8'h00, -1, -1);
        send_frame(8'hBB, 5'd9, 3'd2, 8'hC3, -1, 8'h00, -1, 500);
        check("mrst_done", 32'(frame_done_o), 32'd0);
        check("mrst_ok", 32'(frame_ok_o), 32'd0);
        check("mrst_kind_dw_flags", {18'd0, frame_kind_o, dangwei_o, err_flags_o}, 32'd0);
        check("mrst_state", 32'(fsm_state_o), 32'd0);
        check_counts("mrst", 16'd0, 16'd0, 16'd0);
        idle(1);
        push_exp(1'b1, 2'd0, 4'h0, 8'h5A);
        send_frame(8'hBB, 5'd9, 3'd1, 8'h5A, -1, 8'h00, -1, -1);
        idle(3);
        check_counts("post_rst", 16'd1, 16'd0, 16'd0);

        check("pending_results", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
